// File: rtl/bp_common_cfg_link_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_common_cfg_link_pkg
// Brief  : Shared cfg-link types: sequencer states and the {addr,data} entry.
// Rev    : 1.0
// ============================================================================

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

`ifndef BP_CFG_ENTRY_S_DECLARE
`define BP_CFG_ENTRY_S_DECLARE(addr_w, data_w) \
  typedef struct packed {                      \
    logic [(addr_w)-1:0] addr;                 \
    logic [(data_w)-1:0] data;                 \
  } bp_cfg_entry_s;
`endif

package bp_common_cfg_link_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_fetch = 2'd1,
    e_send  = 2'd2,
    e_done  = 2'd3
  } bp_cfg_seq_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_cfg_seq_cursor.sv
`default_nettype none
// ============================================================================
// Module : bp_cfg_seq_cursor
// Brief  : Nested core/entry counter; entry is the inner loop, core the outer.
// Rev    : 1.0
// ============================================================================

module bp_cfg_seq_cursor
  #(parameter int num_core_p    = 1,
    parameter int num_entries_p = 4,
    localparam int lg_core_lp    = `BSG_SAFE_CLOG2(num_core_p),
    localparam int lg_entries_lp = `BSG_SAFE_CLOG2(num_entries_p))
  (input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     clear_i,
   input  logic                     inc_i,
   output logic [lg_core_lp-1:0]    core_o,
   output logic [lg_entries_lp-1:0] entry_o,
   output logic                     last_entry_o,
   output logic                     last_core_o);

  localparam logic [lg_core_lp-1:0]    c_last_core  = lg_core_lp'(num_core_p - 1);
  localparam logic [lg_entries_lp-1:0] c_last_entry = lg_entries_lp'(num_entries_p - 1);

  logic [lg_core_lp-1:0]    r_core;
  logic [lg_entries_lp-1:0] r_entry;

  assign core_o       = r_core;
  assign entry_o      = r_entry;
  assign last_entry_o = (r_entry == c_last_entry);
  assign last_core_o  = (r_core == c_last_core);

  // Core saturates at its last value so the counter never wraps.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_core  <= '0;
      r_entry <= '0;
    end else if (clear_i) begin
      r_core  <= '0;
      r_entry <= '0;
    end else if (inc_i) begin
      if (last_entry_o) begin
        r_entry <= '0;
        if (!last_core_o)
          r_core <= r_core + lg_core_lp'(1);
      end else begin
        r_entry <= r_entry + lg_entries_lp'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : bp_cfg_sequencer
// Brief  : Boot-time cfg master; streams per-core ROM writes, then unfreezes.
// Rev    : 1.0
// ============================================================================

module bp_cfg_sequencer
  import bp_common_cfg_link_pkg::*;
  #(parameter int num_core_p       = 1,
    parameter int num_entries_p    = 4,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    localparam int lg_entries_lp   = `BSG_SAFE_CLOG2(num_entries_p))
  (input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic                                     start_i,
   output logic                                     rom_v_o,
   output logic [lg_entries_lp-1:0]                 rom_addr_o,
   input  logic [cfg_addr_width_p+cfg_data_width_p-1:0] rom_data_i,
   output logic                                     cfg_v_o,
   output logic [cfg_core_width_p-1:0]              cfg_core_o,
   output logic [cfg_addr_width_p-1:0]              cfg_addr_o,
   output logic [cfg_data_width_p-1:0]              cfg_data_o,
   input  logic                                     cfg_ready_i,
   output logic [num_core_p-1:0]                    freeze_o,
   output logic                                     busy_o,
   output logic                                     done_o);

  `BP_CFG_ENTRY_S_DECLARE(cfg_addr_width_p, cfg_data_width_p)

  localparam int c_lg_core = `BSG_SAFE_CLOG2(num_core_p);

  bp_cfg_seq_state_e          r_state;
  bp_cfg_entry_s              r_payload;
  bp_cfg_entry_s              w_rom_entry;
  bp_cfg_entry_s              w_cur_entry;
  logic                       r_first;
  logic                       r_rom_v;
  logic                       r_cfg_v;
  logic                       r_busy;
  logic                       r_done;
  logic [num_core_p-1:0]      r_freeze;
  logic [num_core_p-1:0]      w_core_mask;
  logic [c_lg_core-1:0]       w_core_cnt;
  logic [lg_entries_lp-1:0]   w_entry_cnt;
  logic                       w_last_entry;
  logic                       w_last_core;
  logic                       w_start;
  logic                       w_hs;

  assign w_rom_entry = rom_data_i;
  assign w_start     = start_i & ((r_state == e_idle) | (r_state == e_done));
  assign w_hs        = r_cfg_v & cfg_ready_i;

  bp_cfg_seq_cursor
    #(.num_core_p    (num_core_p),
      .num_entries_p (num_entries_p))
    u_cursor
     (.clk_i        (clk_i),
      .reset_i      (reset_i),
      .clear_i      (w_start),
      .inc_i        (w_hs),
      .core_o       (w_core_cnt),
      .entry_o      (w_entry_cnt),
      .last_entry_o (w_last_entry),
      .last_core_o  (w_last_core));

  for (genvar g = 0; g < num_core_p; g++) begin : g_core_mask
    assign w_core_mask[g] = (w_core_cnt == c_lg_core'(g));
  end

  // The ROM word is only valid in the first SEND cycle, so it is forwarded
  // directly then and served from the captured copy while backpressured.
  assign w_cur_entry = r_first ? w_rom_entry : r_payload;

  assign rom_v_o    = r_rom_v;
  assign rom_addr_o = w_entry_cnt;
  assign cfg_v_o    = r_cfg_v;
  assign cfg_core_o = cfg_core_width_p'(w_core_cnt);
  assign cfg_addr_o = w_cur_entry.addr;
  assign cfg_data_o = w_cur_entry.data;
  assign freeze_o   = r_freeze;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= e_idle;
      r_payload <= '0;
      r_first   <= 1'b0;
      r_rom_v   <= 1'b0;
      r_cfg_v   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_freeze  <= '1;
    end else begin
      case (r_state)
        e_idle, e_done: begin
          if (w_start) begin
            r_state  <= e_fetch;
            r_rom_v  <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_freeze <= '1;
          end
        end
        e_fetch: begin
          r_state <= e_send;
          r_rom_v <= 1'b0;
          r_cfg_v <= 1'b1;
          r_first <= 1'b1;
        end
        e_send: begin
          if (r_first) begin
            r_payload <= w_rom_entry;
            r_first   <= 1'b0;
          end
          if (w_hs) begin
            r_cfg_v <= 1'b0;
            if (w_last_entry)
              r_freeze <= r_freeze & ~w_core_mask;
            if (w_last_entry && w_last_core) begin
              r_state <= e_done;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= e_fetch;
              r_rom_v <= 1'b1;
            end
          end
        end
        default: r_state <= e_idle;
      endcase
    end
  end

endmodule

`default_nettype wire
